// File: rtl/srl_fifo_ctrl.sv
// Control for an external SRL-based FIFO with a registered first-word-fall-through output stage.
// Define SRL_FIFO_OCCUPANCY_EN to add the registered if_num_data_valid occupancy output.
module srl_fifo_ctrl #(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 2,
   parameter int DEPTH      = 3
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_full_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_empty_n,
`ifdef SRL_FIFO_OCCUPANCY_EN
   output logic [ADDR_WIDTH:0]   if_num_data_valid,
`endif
   output logic                  shift_we,
   output logic [DATA_WIDTH-1:0] shift_din,
   output logic [ADDR_WIDTH-1:0] shift_addr,
   input  logic [DATA_WIDTH-1:0] shift_dout
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_MORE  = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH:0] CNT_ZERO  = '0;
   localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0] CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH:0]     srl_cnt_q, srl_cnt_d;
   logic [ADDR_WIDTH-1:0]   shift_addr_q, shift_addr_d;
   logic [DATA_WIDTH-1:0]   dout_q, dout_d;
   logic                    full_n_q, full_n_d;
   logic                    empty_n_q, empty_n_d;
   logic                    we_d;
   logic                    push, pop;

   // Requests are qualified by the registered flags, so a full FIFO never accepts a write
   // even when a read drains it on the same edge.
   assign push = if_write & if_write_ce & full_n_q;
   assign pop  = if_read  & if_read_ce  & empty_n_q;

   always_comb begin
      state_d   = state_q;
      srl_cnt_d = srl_cnt_q;
      dout_d    = dout_q;
      we_d      = 1'b0;

      unique case (state_q)
         ST_EMPTY: begin
            if (push) begin
               dout_d  = if_din;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (push && !pop) begin
               we_d      = 1'b1;
               srl_cnt_d = CNT_ONE;
               state_d   = ST_MORE;
            end else if (pop && !push) begin
               state_d = ST_EMPTY;
            end else if (push && pop) begin
               dout_d = if_din;
            end
         end
         ST_MORE: begin
            if (pop && !push) begin
               dout_d    = shift_dout;
               srl_cnt_d = srl_cnt_q - CNT_ONE;
               if (srl_cnt_q == CNT_ONE) begin
                  state_d = ST_ONE;
               end
            end else if (push && !pop) begin
               we_d      = 1'b1;
               srl_cnt_d = srl_cnt_q + CNT_ONE;
            end else if (push && pop) begin
               // Oldest entry is read before the shift; after the shift it sits at the same index.
               dout_d = shift_dout;
               we_d   = 1'b1;
            end
         end
         default: begin
            state_d   = ST_EMPTY;
            srl_cnt_d = CNT_ZERO;
         end
      endcase

      shift_addr_d = (srl_cnt_d != CNT_ZERO) ? ADDR_WIDTH'(srl_cnt_d - CNT_ONE) : '0;
      full_n_d     = (srl_cnt_d != CNT_DEPTH);
      empty_n_d    = (state_d != ST_EMPTY);
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state_q      <= ST_EMPTY;
         srl_cnt_q    <= CNT_ZERO;
         shift_addr_q <= '0;
         dout_q       <= '0;
         full_n_q     <= 1'b1;
         empty_n_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         srl_cnt_q    <= srl_cnt_d;
         shift_addr_q <= shift_addr_d;
         dout_q       <= dout_d;
         full_n_q     <= full_n_d;
         empty_n_q    <= empty_n_d;
      end
   end

`ifdef SRL_FIFO_OCCUPANCY_EN
   logic [ADDR_WIDTH:0] occ_q, occ_d;

   always_comb begin
      occ_d = srl_cnt_d + {{ADDR_WIDTH{1'b0}}, (state_d != ST_EMPTY)};
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign if_num_data_valid = occ_q;
`endif

   assign shift_we   = we_d & ap_rst_n;
   assign shift_din  = if_din;
   assign shift_addr = shift_addr_q;
   assign if_dout    = dout_q;
   assign if_full_n  = full_n_q;
   assign if_empty_n = empty_n_q;

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Scoreboard bench for srl_fifo_ctrl with a behavioural SRL; honours SRL_FIFO_OCCUPANCY_EN.
module tb_srl_fifo_ctrl;

   localparam int DW = 8;
   localparam int AW = 2;
   localparam int DP = 3;

   logic          ap_clk = 1'b0;
   logic          ap_rst_n = 1'b0;
   logic          if_write_ce = 1'b0;
   logic          if_write = 1'b0;
   logic [DW-1:0] if_din = '0;
   logic          if_full_n;
   logic          if_read_ce = 1'b0;
   logic          if_read = 1'b0;
   logic [DW-1:0] if_dout;
   logic          if_empty_n;
   logic          shift_we;
   logic [DW-1:0] shift_din;
   logic [AW-1:0] shift_addr;
   logic [DW-1:0] shift_dout;
`ifdef SRL_FIFO_OCCUPANCY_EN
   logic [AW:0]   if_num_data_valid;
`endif

   int vectors = 0;
   int miscompares = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] mon_exp;
   logic [DW-1:0] srl [0:(1<<AW)-1];

   always #5 ap_clk = ~ap_clk;

   srl_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
      .ap_clk            (ap_clk),
      .ap_rst_n          (ap_rst_n),
      .if_write_ce       (if_write_ce),
      .if_write          (if_write),
      .if_din            (if_din),
      .if_full_n         (if_full_n),
      .if_read_ce        (if_read_ce),
      .if_read           (if_read),
      .if_dout           (if_dout),
      .if_empty_n        (if_empty_n),
`ifdef SRL_FIFO_OCCUPANCY_EN
      .if_num_data_valid (if_num_data_valid),
`endif
      .shift_we          (shift_we),
      .shift_din         (shift_din),
      .shift_addr        (shift_addr),
      .shift_dout        (shift_dout)
   );

   // Behavioural shift register: new data enters at index 0
   always @(posedge ap_clk) begin
      if (shift_we) begin
         for (int i = (1<<AW)-1; i > 0; i--) srl[i] <= srl[i-1];
         srl[0] <= shift_din;
      end
   end
   assign shift_dout = srl[shift_addr];

   // Monitor: every accepted pop must present the oldest expected word
   always @(negedge ap_clk) begin
      if (ap_rst_n && if_read && if_read_ce && if_empty_n) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL pop_underflow: dout=%0h but no entry expected", if_dout);
         end else begin
            mon_exp = exp_q.pop_front();
            if (if_dout !== mon_exp) begin
               miscompares++;
               $display("FAIL pop_data: got %0h expected %0h", if_dout, mon_exp);
            end else begin
               $display("pop  dout=%0h ok", if_dout);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One cycle of traffic; acc says whether the write must be accepted, exp_we < 0 skips the shift_we check
   task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic acc, input int exp_we);
      if_write    = w;
      if_din      = d;
      if_read     = r;
      if_write_ce = 1'b1;
      if_read_ce  = 1'b1;
      if (acc) exp_q.push_back(d);
      #1;
      if (exp_we >= 0) chk("shift_we", {31'd0, shift_we}, exp_we);
      @(posedge ap_clk);
      #1;
      if_write = 1'b0;
      if_read  = 1'b0;
   endtask

   task automatic chk_occ(input int exp);
`ifdef SRL_FIFO_OCCUPANCY_EN
      chk("num_data_valid", {29'd0, if_num_data_valid}, exp);
`else
      if (exp < 0) $display("occupancy %0d", exp);
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < (1<<AW); i++) srl[i] = '0;
      repeat (2) @(posedge ap_clk);
      #1;
      chk("rst_empty_n", {31'd0, if_empty_n}, 0);
      chk("rst_full_n", {31'd0, if_full_n}, 1);
      chk("rst_dout", {24'd0, if_dout}, 0);
      chk("rst_addr", {30'd0, shift_addr}, 0);
      chk_occ(0);
      ap_rst_n = 1'b1;

      // First-word latency
      step(1, 8'h01, 0, 1, 0);
      chk("lat_empty_n", {31'd0, if_empty_n}, 1);
      chk("lat_dout", {24'd0, if_dout}, 8'h01);
      chk("lat_full_n", {31'd0, if_full_n}, 1);
      step(0, 0, 1, 0, -1);
      chk("drain_empty_n", {31'd0, if_empty_n}, 0);

      // Fill to DEPTH+1, then a rejected push
      step(1, 8'h01, 0, 1, 0);
      step(1, 8'h02, 0, 1, 1);
      step(1, 8'h03, 0, 1, 1);
      chk("fill3_full_n", {31'd0, if_full_n}, 1);
      step(1, 8'h04, 0, 1, 1);
      chk("full_full_n", {31'd0, if_full_n}, 0);
      chk("full_addr", {30'd0, shift_addr}, 2);
      chk_occ(4);
      step(1, 8'h05, 0, 0, 0);
      chk("rej_full_n", {31'd0, if_full_n}, 0);
      chk("rej_dout", {24'd0, if_dout}, 8'h01);

      // Full with push+pop: pop wins, push rejected
      step(1, 8'h06, 1, 0, 0);
      chk("fp_full_n", {31'd0, if_full_n}, 1);
      chk("fp_dout", {24'd0, if_dout}, 8'h02);
      chk_occ(3);
      repeat (3) step(0, 0, 1, 0, 0);
      chk("fp_empty_n", {31'd0, if_empty_n}, 0);

      // Sustained push+pop from ONE
      step(1, 8'd0, 0, 1, 0);
      for (int i = 1; i < 100; i++) step(1, DW'(i), 1, 1, 0);
      chk("one_addr", {30'd0, shift_addr}, 0);
      chk_occ(1);
      step(0, 0, 1, 0, -1);

      // Sustained push+pop in MORE with two SRL entries
      step(1, 8'd100, 0, 1, 0);
      step(1, 8'd101, 0, 1, 1);
      step(1, 8'd102, 0, 1, 1);
      for (int i = 103; i < 140; i++) begin
         step(1, DW'(i), 1, 1, 1);
         if (i % 12 == 0) chk("more_addr", {30'd0, shift_addr}, 1);
      end
      chk("more_full_n", {31'd0, if_full_n}, 1);
      chk_occ(3);
      repeat (3) step(0, 0, 1, 0, -1);
      chk("more_empty_n", {31'd0, if_empty_n}, 0);

      // Reset mid-push with entries in the SRL
      step(1, 8'h11, 0, 1, 0);
      step(1, 8'h22, 0, 1, 1);
      step(1, 8'h33, 0, 1, 1);
      ap_rst_n = 1'b0;
      if_write = 1'b1;
      if_din = 8'h44;
      #1;
      chk("rst_we_forced", {31'd0, shift_we}, 0);
      @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;
      if_write = 1'b0;
      exp_q.delete();
      chk("mrst_empty_n", {31'd0, if_empty_n}, 0);
      chk("mrst_full_n", {31'd0, if_full_n}, 1);
      chk("mrst_dout", {24'd0, if_dout}, 0);
      chk("mrst_addr", {30'd0, shift_addr}, 0);
      chk_occ(0);
      step(1, 8'h0A, 0, 1, 0);
      step(0, 0, 1, 0, -1);

      // Clock-enables low: requests ignored
      step(1, 8'h55, 0, 1, 0);
      step(1, 8'h66, 0, 1, 1);
      if_write = 1'b1;
      if_read = 1'b1;
      if_din = 8'h77;
      if_write_ce = 1'b0;
      if_read_ce = 1'b0;
      #1;
      chk("ce_we", {31'd0, shift_we}, 0);
      repeat (2) @(posedge ap_clk);
      #1;
      chk("ce_dout", {24'd0, if_dout}, 8'h55);
      chk("ce_empty_n", {31'd0, if_empty_n}, 1);
      chk("ce_addr", {30'd0, shift_addr}, 0);
      chk_occ(2);
      repeat (2) step(0, 0, 1, 0, -1);
      chk("end_empty_n", {31'd0, if_empty_n}, 0);
      chk("end_queue", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
